mmc_card_target: RTL

Synthesizable SPI-mode MMC card responder: the card end of the link driven by `mmc_block_dev`. It decodes host commands on `mmc_cs`/`mmc_sclk`/`mmc_do`, answers on `mmc_di`, and serves 512-byte block reads and writes from a byte-wide memory port. It sits in place of the external card for FPGA self-test and bench runs, backed by on-chip RAM or SDRAM glue.

---
 rtl/mmc_card_target.sv | 327 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mmc_card_target.sv
// SPI-mode MMC card responder: decodes host commands and serves
// 512-byte block reads/writes from a byte-wide memory port.
module mmc_card_target #(
   parameter int ADDR_W     = 18,
   parameter int BUSY_BYTES = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              mmc_cs,
   input  logic              mmc_sclk,
   input  logic              mmc_do,
   output logic              mmc_di,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [7:0]        mem_rdata,
   output logic              mem_wr,
   output logic [7:0]        mem_wdata,
   output logic              card_idle,
   output logic [3:0]        card_state
);
   localparam int BLK_W = ADDR_W - 9;

   typedef enum logic [3:0] {
      S_HUNT,
      S_CMD,
      S_NCR,
      S_RESP,
      S_RGAP,
      S_RTOK,
      S_RDATA,
      S_RCRC,
      S_WTOK,
      S_WDATA,
      S_WCRC,
      S_WRESP,
      S_BUSY
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        sclk_q, sclk_d;
   logic [1:0]        cs_q, cs_d;
   logic [1:0]        do_q, do_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        rx_q, rx_d;
   logic [7:0]        tx_q, tx_d;
   logic              di_q, di_d;
   logic [8:0]        cnt_q, cnt_d;
   logic [5:0]        cmd_q, cmd_d;
   logic [31:0]       arg_q, arg_d;
   logic [7:0]        r1_q, r1_d;
   logic              idle_q, idle_d;
   logic              rd_op_q, rd_op_d;
   logic              wr_op_q, wr_op_d;
   logic [BLK_W-1:0]  blk_q, blk_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic              rd_dly_q, rd_dly_d;
   logic [7:0]        rdata_q, rdata_d;

   logic       sel;
   logic       rise;
   logic       fall;
   logic       rx_done;
   logic       load;
   logic [7:0] rx_byte;
   logic [7:0] tx_next;
   logic [7:0] r1_new;
   logic       idle_new;
   logic       go_rd;
   logic       go_wr;
   logic       arg_hi_ok;

   always_comb begin
      sclk_d = {sclk_q[1:0], mmc_sclk};
      cs_d   = {cs_q[0], mmc_cs};
      do_d   = {do_q[0], mmc_do};
   end

   assign sel     = ~cs_q[1];
   assign rise    = sel & sclk_q[1] & ~sclk_q[2];
   assign fall    = sel & ~sclk_q[1] & sclk_q[2];
   assign rx_byte = {rx_q[6:0], do_q[1]};
   assign rx_done = rise & (bit_q == 3'd7);
   assign load    = fall & (bit_q == 3'd0);

   // Byte presented in the slot that starts at the next loading fall
   always_comb begin
      tx_next = 8'hFF;
      case (state_q)
         S_RESP:  tx_next = r1_q;
         S_RTOK:  tx_next = 8'hFE;
         S_RDATA: tx_next = rdata_q;
         S_WRESP: tx_next = 8'h05;
         S_BUSY:  tx_next = 8'h00;
         default: tx_next = 8'hFF;
      endcase
   end

   always_comb begin
      bit_d = bit_q;
      rx_d  = rx_q;
      tx_d  = tx_q;
      di_d  = di_q;
      if (!sel) begin
         bit_d = 3'd0;
         tx_d  = 8'hFF;
         di_d  = 1'b1;
      end else begin
         if (rise) begin
            rx_d  = rx_byte;
            bit_d = bit_q + 3'd1;
         end
         if (load) begin
            di_d = tx_next[7];
            tx_d = {tx_next[6:0], 1'b1};
         end else if (fall) begin
            di_d = tx_q[7];
            tx_d = {tx_q[6:0], 1'b1};
         end
      end
   end

   assign arg_hi_ok = (arg_q >> ADDR_W) == 32'd0;

   always_comb begin
      r1_new   = 8'h04 | {7'd0, idle_q};
      idle_new = idle_q;
      go_rd    = 1'b0;
      go_wr    = 1'b0;
      case (cmd_q)
         6'd0: begin
            r1_new   = 8'h01;
            idle_new = 1'b1;
         end
         6'd1: begin
            r1_new   = {7'd0, idle_q};
            idle_new = 1'b0;
         end
         6'd16: begin
            r1_new = (arg_q == 32'd512) ? 8'h00 : 8'h40;
            r1_new = r1_new | {7'd0, idle_q};
         end
         6'd17, 6'd24: begin
            if (idle_q) begin
               r1_new = 8'h05;
            end else if (!arg_hi_ok) begin
               r1_new = 8'h40;
            end else begin
               r1_new = 8'h00;
               go_rd  = (cmd_q == 6'd17);
               go_wr  = (cmd_q == 6'd24);
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cmd_d    = cmd_q;
      arg_d    = arg_q;
      r1_d     = r1_q;
      idle_d   = idle_q;
      rd_op_d  = rd_op_q;
      wr_op_d  = wr_op_q;
      blk_d    = blk_q;
      addr_d   = addr_q;
      rd_d     = 1'b0;
      wr_d     = 1'b0;
      wdata_d  = wdata_q;
      rd_dly_d = rd_q;
      rdata_d  = rd_dly_q ? mem_rdata : rdata_q;
      if (!sel) begin
         state_d = S_HUNT;
      end else begin
         if (rx_done) begin
            case (state_q)
               S_HUNT: begin
                  if (rx_byte[7:6] == 2'b01) begin
                     state_d = S_CMD;
                     cmd_d   = rx_byte[5:0];
                     cnt_d   = 9'd0;
                  end
               end
               S_CMD: begin
                  cnt_d = cnt_q + 9'd1;
                  if (cnt_q == 9'd4) begin
                     state_d = S_NCR;
                     r1_d    = r1_new;
                     idle_d  = idle_new;
                     rd_op_d = go_rd;
                     wr_op_d = go_wr;
                     blk_d   = arg_q[ADDR_W-1:9];
                  end else begin
                     arg_d = {arg_q[23:0], rx_byte};
                  end
               end
               S_NCR: state_d = S_RESP;
               S_RESP: begin
                  cnt_d = 9'd0;
                  if (rd_op_q)
                     state_d = S_RGAP;
                  else if (wr_op_q)
                     state_d = S_WTOK;
                  else
                     state_d = S_HUNT;
               end
               S_RGAP: state_d = S_RTOK;
               S_RTOK: begin
                  state_d = S_RDATA;
                  cnt_d   = 9'd0;
               end
               S_RDATA: begin
                  cnt_d = cnt_q + 9'd1;
                  if (cnt_q == 9'h1FF)
                     state_d = S_RCRC;
               end
               S_RCRC: begin
                  cnt_d = cnt_q + 9'd1;
                  if (cnt_q == 9'd1)
                     state_d = S_HUNT;
               end
               S_WTOK: begin
                  cnt_d = 9'd0;
                  if (rx_byte == 8'hFE)
                     state_d = S_WDATA;
                  else if (rx_byte != 8'hFF)
                     state_d = S_HUNT;
               end
               S_WDATA: begin
                  wr_d    = 1'b1;
                  addr_d  = {blk_q, cnt_q};
                  wdata_d = rx_byte;
                  cnt_d   = cnt_q + 9'd1;
                  if (cnt_q == 9'h1FF)
                     state_d = S_WCRC;
               end
               S_WCRC: begin
                  cnt_d = cnt_q + 9'd1;
                  if (cnt_q == 9'd1)
                     state_d = S_WRESP;
               end
               S_WRESP: begin
                  cnt_d   = 9'd0;
                  state_d = (BUSY_BYTES == 0) ? S_HUNT : S_BUSY;
               end
               S_BUSY: begin
                  cnt_d = cnt_q + 9'd1;
                  if (cnt_q == 9'(BUSY_BYTES - 1))
                     state_d = S_HUNT;
               end
               default: state_d = S_HUNT;
            endcase
         end
         // Prefetch the byte for the following slot a whole slot ahead
         if (load && state_q == S_RTOK) begin
            rd_d   = 1'b1;
            addr_d = {blk_q, 9'd0};
         end else if (load && state_q == S_RDATA && cnt_q != 9'h1FF) begin
            rd_d   = 1'b1;
            addr_d = {blk_q, cnt_q + 9'd1};
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sclk_q   <= '0;
         cs_q     <= '1;
         do_q     <= '0;
         bit_q    <= '0;
         rx_q     <= '0;
         tx_q     <= '1;
         di_q     <= 1'b1;
         state_q  <= S_HUNT;
         cnt_q    <= '0;
         cmd_q    <= '0;
         arg_q    <= '0;
         r1_q     <= '1;
         idle_q   <= 1'b1;
         rd_op_q  <= 1'b0;
         wr_op_q  <= 1'b0;
         blk_q    <= '0;
         addr_q   <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         wdata_q  <= '0;
         rd_dly_q <= 1'b0;
         rdata_q  <= '1;
      end else begin
         sclk_q   <= sclk_d;
         cs_q     <= cs_d;
         do_q     <= do_d;
         bit_q    <= bit_d;
         rx_q     <= rx_d;
         tx_q     <= tx_d;
         di_q     <= di_d;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cmd_q    <= cmd_d;
         arg_q    <= arg_d;
         r1_q     <= r1_d;
         idle_q   <= idle_d;
         rd_op_q  <= rd_op_d;
         wr_op_q  <= wr_op_d;
         blk_q    <= blk_d;
         addr_q   <= addr_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         wdata_q  <= wdata_d;
         rd_dly_q <= rd_dly_d;
         rdata_q  <= rdata_d;
      end
   end

   assign mmc_di     = di_q;
   assign mem_addr   = addr_q;
   assign mem_rd     = rd_q;
   assign mem_wr     = wr_q;
   assign mem_wdata  = wdata_q;
   assign card_idle  = idle_q;
   assign card_state = state_q;

endmodule
